// File: rtl/run_ctrl.sv
// run_ctrl: program sequencer and run controller for the single-cycle core.
// Owns the program counter, the Start/Ack handshake, entry-point selection
// and the saturating cycle / retired-instruction counters.
module run_ctrl #(
    parameter int PC_W   = 10,
    parameter int PROG_N = 4,
    parameter int OFF_W  = 6,
    parameter int CNT_W  = 16,
    localparam int SEL_W = (PROG_N > 1) ? $clog2(PROG_N) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   Start,
    input  logic [SEL_W-1:0]       ProgSel,
    input  logic [PROG_N*PC_W-1:0] ProgBase,
    input  logic                   Stall,
    input  logic                   Halt,
    input  logic                   BranchAbs,
    input  logic                   BranchRelEn,
    input  logic                   Flag,
    input  logic [PC_W-1:0]        Target,
    input  logic [OFF_W-1:0]       Offset,
    output logic [PC_W-1:0]        ProgCtr,
    output logic                   Run,
    output logic                   Ack,
    output logic                   Wrapped,
    output logic [CNT_W-1:0]       CycleCt,
    output logic [CNT_W-1:0]       InstrCt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } runStateT;

    runStateT         stateReg, stateNext;
    logic [PC_W-1:0]  pcReg, pcNext;
    logic             wrapReg, wrapNext;
    logic [CNT_W-1:0] cycReg, cycNext;
    logic [CNT_W-1:0] insReg, insNext;
    logic             runReg, ackReg;

    logic [PC_W-1:0]  entryAddr [PROG_N];
    logic [PC_W-1:0]  selAddr;
    logic [PC_W:0]    incSum;
    logic [PC_W:0]    relSum;

    // Unpack the flat entry-address bus into one address per program
    generate
        for (genvar gi = 0; gi < PROG_N; gi++) begin : gEntry
            assign entryAddr[gi] = ProgBase[gi*PC_W +: PC_W];
        end
    endgenerate

    // Entry select; out-of-range selects fall back to entry 0
    always_comb begin
        selAddr = entryAddr[0];
        for (int i = 1; i < PROG_N; i++) begin
            if (ProgSel == SEL_W'(i)) begin
                selAddr = entryAddr[i];
            end
        end
    end

    // Extra MSB on both adders is the carry/borrow out of the PC width.
    // The offset magnitude never exceeds half the PC range, so the MSB
    // is set exactly when the true sum leaves [0, 2^PC_W-1].
    assign incSum = {1'b0, pcReg} + (PC_W+1)'(1);
    assign relSum = {1'b0, pcReg} + {{(PC_W+1-OFF_W){Offset[OFF_W-1]}}, Offset};

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next-state, next-PC, wrap flag and counter update
    always_comb begin
        stateNext = stateReg;
        pcNext    = pcReg;
        wrapNext  = wrapReg;
        cycNext   = cycReg;
        insNext   = insReg;

        if (Start) begin
            // Start from any state (re)loads the entry and discards the
            // instruction currently at ProgCtr.
            stateNext = LOAD;
            pcNext    = selAddr;
            wrapNext  = 1'b0;
            cycNext   = '0;
            insNext   = '0;
        end else begin
            unique case (stateReg)
                LOAD: begin
                    stateNext = RUN;
                end
                RUN: begin
                    if (Stall) begin
                        cycNext = satInc(cycReg);
                    end else begin
                        cycNext = satInc(cycReg);
                        insNext = satInc(insReg);
                        if (Halt) begin
                            stateNext = DONE;
                        end else if (BranchAbs) begin
                            pcNext = Target;
                        end else if (BranchRelEn && Flag) begin
                            pcNext   = relSum[PC_W-1:0];
                            wrapNext = wrapReg | relSum[PC_W];
                        end else begin
                            pcNext   = incSum[PC_W-1:0];
                            wrapNext = wrapReg | incSum[PC_W];
                        end
                    end
                end
                default: begin
                    // IDLE and DONE hold everything until Start
                end
            endcase
        end
    end

    // State and output registers; reset overrides every other input
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            stateReg <= IDLE;
            pcReg    <= '0;
            wrapReg  <= 1'b0;
            cycReg   <= '0;
            insReg   <= '0;
            runReg   <= 1'b0;
            ackReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            pcReg    <= pcNext;
            wrapReg  <= wrapNext;
            cycReg   <= cycNext;
            insReg   <= insNext;
            runReg   <= (stateNext == RUN);
            ackReg   <= (stateNext == DONE);
        end
    end

    assign ProgCtr = pcReg;
    assign Run     = runReg;
    assign Ack     = ackReg;
    assign Wrapped = wrapReg;
    assign CycleCt = cycReg;
    assign InstrCt = insReg;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed scenarios followed by random stimulus, all
// checked every cycle against a behavioural model. A second instance with
// 4-bit counters shares the stimulus to exercise saturation.
module tb_run_ctrl;

    localparam int PC_W  = 10;
    localparam int OFF_W = 6;
    localparam int PC_MAX = (1 << PC_W) - 1;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;

    logic        Clk = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  progSel = '0;
    logic [39:0] progBase = '0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        branchAbs = 1'b0;
    logic        branchRelEn = 1'b0;
    logic        flag = 1'b0;
    logic [9:0]  target = '0;
    logic [5:0]  offset = '0;

    logic [9:0]  pcA, pcB;
    logic        runA, runB, ackA, ackB, wrapA, wrapB;
    logic [15:0] cycA, insA;
    logic [3:0]  cycB, insB;

    int testsRun = 0;
    int failCt = 0;

    // Behavioural model
    int mMode = M_IDLE;
    int mPc = 0;
    bit mWrap = 1'b0;
    int mCyc = 0;
    int mIns = 0;

    always #5 Clk = ~Clk;

    run_ctrl #(.PC_W(10), .PROG_N(4), .OFF_W(6), .CNT_W(16)) dutA (
        .Clk(Clk), .Reset_n(resetN), .Start(start), .ProgSel(progSel),
        .ProgBase(progBase), .Stall(stall), .Halt(halt), .BranchAbs(branchAbs),
        .BranchRelEn(branchRelEn), .Flag(flag), .Target(target), .Offset(offset),
        .ProgCtr(pcA), .Run(runA), .Ack(ackA), .Wrapped(wrapA),
        .CycleCt(cycA), .InstrCt(insA)
    );

    run_ctrl #(.PC_W(10), .PROG_N(4), .OFF_W(6), .CNT_W(4)) dutB (
        .Clk(Clk), .Reset_n(resetN), .Start(start), .ProgSel(progSel),
        .ProgBase(progBase), .Stall(stall), .Halt(halt), .BranchAbs(branchAbs),
        .BranchRelEn(branchRelEn), .Flag(flag), .Target(target), .Offset(offset),
        .ProgCtr(pcB), .Run(runB), .Ack(ackB), .Wrapped(wrapB),
        .CycleCt(cycB), .InstrCt(insB)
    );

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            failCt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int satVal(input int v, input int maxV);
        return (v > maxV) ? maxV : v;
    endfunction

    // Apply one clock edge of the behavioural rules to the model
    task automatic modelStep();
        int sum;
        if (!resetN) begin
            mMode = M_IDLE; mPc = 0; mWrap = 1'b0; mCyc = 0; mIns = 0;
        end else if (start) begin
            mMode = M_LOAD;
            mPc   = int'(progBase[progSel*PC_W +: PC_W]);
            mWrap = 1'b0; mCyc = 0; mIns = 0;
        end else if (mMode == M_LOAD) begin
            mMode = M_RUN;
        end else if (mMode == M_RUN) begin
            mCyc++;
            if (!stall) begin
                mIns++;
                if (halt) begin
                    mMode = M_DONE;
                end else if (branchAbs) begin
                    mPc = int'(target);
                end else begin
                    if (branchRelEn && flag) sum = mPc + int'($signed(offset));
                    else                     sum = mPc + 1;
                    if (sum < 0 || sum > PC_MAX) mWrap = 1'b1;
                    mPc = (sum + PC_MAX + 1) % (PC_MAX + 1);
                end
            end
        end
    endtask

    task automatic checkAll();
        checkEq("pcA",   64'(pcA),   64'(mPc));
        checkEq("runA",  64'(runA),  64'(mMode == M_RUN));
        checkEq("ackA",  64'(ackA),  64'(mMode == M_DONE));
        checkEq("wrapA", 64'(wrapA), 64'(mWrap));
        checkEq("cycA",  64'(cycA),  64'(satVal(mCyc, 65535)));
        checkEq("insA",  64'(insA),  64'(satVal(mIns, 65535)));
        checkEq("pcB",   64'(pcB),   64'(mPc));
        checkEq("runB",  64'(runB),  64'(mMode == M_RUN));
        checkEq("ackB",  64'(ackB),  64'(mMode == M_DONE));
        checkEq("wrapB", 64'(wrapB), 64'(mWrap));
        checkEq("cycB",  64'(cycB),  64'(satVal(mCyc, 15)));
        checkEq("insB",  64'(insB),  64'(satVal(mIns, 15)));
    endtask

    task automatic step();
        @(posedge Clk);
        modelStep();
        #1;
        checkAll();
        $display("[TB] t=%0t rst_n=%0b start=%0b stall=%0b halt=%0b pc=%0d run=%0b ack=%0b wrap=%0b cyc=%0d ins=%0d",
                 $time, resetN, start, stall, halt, pcA, runA, ackA, wrapA, cycA, insA);
    endtask

    task automatic clearCtl();
        start = 1'b0; stall = 1'b0; halt = 1'b0;
        branchAbs = 1'b0; branchRelEn = 1'b0; flag = 1'b0;
    endtask

    // Start pulse for one cycle from the given entry, then enter RUN
    task automatic launch(input logic [1:0] sel);
        clearCtl();
        progSel = sel; start = 1'b1; step();
        start = 1'b0; step();
    endtask

    task automatic jumpTo(input logic [9:0] addr);
        clearCtl(); branchAbs = 1'b1; target = addr; step();
        branchAbs = 1'b0;
    endtask

    initial begin
        int cycBefore, insBefore;
        logic [9:0] pcBefore;

        // Reset for two cycles
        resetN = 1'b0; step(); step();
        checkEq("rst_pc",  64'(pcA),  64'd0);
        checkEq("rst_run", 64'(runA), 64'd0);
        checkEq("rst_ack", 64'(ackA), 64'd0);
        checkEq("rst_cyc", 64'(cycA), 64'd0);
        resetN = 1'b1;

        // Entry select
        progBase = {10'd300, 10'd200, 10'd100, 10'd0};
        launch(2'd2);
        checkEq("load_pc",  64'(pcA),  64'd200);
        checkEq("load_run", 64'(runA), 64'd1);

        // Sequential run and halt from entry 0
        launch(2'd0);
        clearCtl();
        for (int i = 0; i < 5; i++) step();
        halt = 1'b1; step(); halt = 1'b0;
        checkEq("halt_ack", 64'(ackA), 64'd1);
        checkEq("halt_pc",  64'(pcA),  64'd5);
        checkEq("halt_cyc", 64'(cycA), 64'd6);
        checkEq("halt_ins", 64'(insA), 64'd6);
        for (int i = 0; i < 10; i++) step();
        checkEq("hold_pc",  64'(pcA),  64'd5);
        checkEq("hold_ack", 64'(ackA), 64'd1);

        // Restart from DONE drops Ack on the sampling edge
        progSel = 2'd0; start = 1'b1; step();
        checkEq("restart_ack", 64'(ackA), 64'd0);
        start = 1'b0; step();

        // Branches
        jumpTo(10'd20);
        branchRelEn = 1'b1; flag = 1'b1; offset = 6'(-4); step();
        checkEq("rel_taken", 64'(pcA), 64'd16);
        jumpTo(10'd20);
        branchRelEn = 1'b1; flag = 1'b0; step();
        checkEq("rel_not_taken", 64'(pcA), 64'd21);
        branchAbs = 1'b1; branchRelEn = 1'b1; flag = 1'b1; target = 10'd700; step();
        checkEq("abs_prio", 64'(pcA), 64'd700);
        checkEq("abs_nowrap", 64'(wrapA), 64'd0);

        // Stall priority over halt and branch
        clearCtl();
        pcBefore = pcA; cycBefore = int'(cycA); insBefore = int'(insA);
        stall = 1'b1; halt = 1'b1; branchAbs = 1'b1; target = 10'd3;
        for (int i = 0; i < 3; i++) step();
        checkEq("stall_pc",  64'(pcA),  64'(pcBefore));
        checkEq("stall_cyc", 64'(cycA), 64'(cycBefore + 3));
        checkEq("stall_ins", 64'(insA), 64'(insBefore));
        checkEq("stall_ack", 64'(ackA), 64'd0);
        stall = 1'b0; step();
        checkEq("unstall_halt", 64'(ackA), 64'd1);

        // Wrap on sequential increment
        launch(2'd0);
        jumpTo(10'd1023);
        step();
        checkEq("wrap_inc_pc", 64'(pcA),   64'd0);
        checkEq("wrap_inc",    64'(wrapA), 64'd1);

        // Wrap on relative borrow
        launch(2'd0);
        checkEq("load_clr_wrap", 64'(wrapA), 64'd0);
        jumpTo(10'd2);
        branchRelEn = 1'b1; flag = 1'b1; offset = 6'(-3); step();
        checkEq("wrap_rel_pc", 64'(pcA),   64'd1023);
        checkEq("wrap_rel",    64'(wrapA), 64'd1);

        // Counter saturation on the 4-bit instance
        launch(2'd1);
        clearCtl();
        for (int i = 0; i < 20; i++) step();
        checkEq("sat_cycB", 64'(cycB), 64'd15);
        checkEq("sat_cycA", 64'(cycA), 64'd20);

        // Start mid-run clears counters
        start = 1'b1; step();
        checkEq("mid_start_cyc", 64'(cycA), 64'd0);
        checkEq("mid_start_run", 64'(runA), 64'd0);
        start = 1'b0; step();
        for (int i = 0; i < 4; i++) step();

        // Reset mid-run
        resetN = 1'b0; step();
        checkEq("mid_rst_pc",  64'(pcA),  64'd0);
        checkEq("mid_rst_run", 64'(runA), 64'd0);
        checkEq("mid_rst_cyc", 64'(cycA), 64'd0);
        resetN = 1'b1;

        // Random stimulus
        for (int n = 0; n < 1500; n++) begin
            resetN = ($urandom_range(0, 199) != 0);
            start  = ($urandom_range(0, 19) == 0);
            if (start) begin
                progSel  = 2'($urandom_range(0, 3));
                progBase = {8'($urandom), 32'($urandom)};
            end
            stall       = ($urandom_range(0, 4) == 0);
            halt        = ($urandom_range(0, 29) == 0);
            branchAbs   = ($urandom_range(0, 9) == 0);
            branchRelEn = ($urandom_range(0, 3) == 0);
            flag        = 1'($urandom);
            target      = 10'($urandom);
            offset      = 6'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCt);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Parametrised program sequencer and run controller for the single-cycle core. It owns the program counter, the Start/Ack run handshake, multi-program entry selection and performance counters. It replaces the fixed-width fetch unit and the ad-hoc cycle counter in the top level. The instruction ROM, control decoder and ALU sit around it: the ROM consumes `ProgCtr`, and the decoder and ALU supply the branch, halt and stall inputs.

## Interface
Parameters:
- `PC_W`, 10, program counter and target width
- `PROG_N`, 4, number of selectable program entry points (≥1)
- `OFF_W`, 6, signed relative-branch offset width (≤ PC_W)
- `CNT_W`, 16, width of cycle and instruction counters

Ports:
- `Clk` in 1: clock, posedge only
- `Reset_n` in 1: synchronous, active-low reset; one clock, reset is synchronous and active-low
- `Start` in 1: level request; load selected program entry and (re)start
- `ProgSel` in max(1,$clog2(PROG_N)): entry select, sampled while `Start`=1
- `ProgBase` in PROG_N*PC_W: entry addresses, entry i at bits [i*PC_W +: PC_W]
- `Stall` in 1: current instruction not executed this cycle
- `Halt` in 1: current instruction is the halt opcode
- `BranchAbs` in 1: absolute jump to `Target`
- `BranchRelEn` in 1: relative branch, taken when `Flag`=1
- `Flag` in 1: ALU condition flag
- `Target` in PC_W: absolute jump address
- `Offset` in OFF_W: signed two's-complement relative offset
- `ProgCtr` out PC_W: registered program counter (ROM address)
- `Run` out 1: registered; current `ProgCtr` is a live instruction
- `Ack` out 1: registered done flag
- `Wrapped` out 1: sticky; PC wrapped past 2^PC_W−1 during this run
- `CycleCt` out CNT_W: RUN cycles since last start
- `InstrCt` out CNT_W: retired (non-stalled) instructions since last start

## Operation
- States: IDLE, LOAD, RUN, DONE. `Run`=1 only in RUN. `Ack`=1 only in DONE.
- Reset (`Reset_n`=0 at posedge): state IDLE; `ProgCtr`=0, `Run`=0, `Ack`=0, `Wrapped`=0, `CycleCt`=0, `InstrCt`=0. Reset wins over every input, including mid-run.
- IDLE/DONE with `Start`=1: go to LOAD.
- LOAD:
  - Each cycle: `ProgCtr` ← `ProgBase[ProgSel]`; counters and `Wrapped` cleared; `Ack`=0.
  - `ProgSel` ≥ PROG_N selects entry 0.
  - Stay in LOAD while `Start`=1; go to RUN on the first cycle `Start`=0.
- RUN, per cycle, first matching rule wins:
  1. `Start`=1: go to LOAD. Current instruction is discarded; counters are not incremented.
  2. `Stall`=1: `ProgCtr` holds; `CycleCt`++; `InstrCt` holds. `Halt` and branches are ignored.
  3. `Halt`=1: go to DONE; `ProgCtr` holds at the halt address; `CycleCt`++, `InstrCt`++.
  4. Otherwise: `CycleCt`++, `InstrCt`++. Next PC is chosen by:
     - `BranchAbs`=1: `Target`.
     - else `BranchRelEn`=1 and `Flag`=1: `ProgCtr` + sign-extended `Offset`, modulo 2^PC_W.
     - else `ProgCtr`+1, modulo 2^PC_W.
- `Wrapped` sets when a sequential increment or a relative add carries or borrows out of PC_W bits. It is not set by absolute jumps. It stays set until LOAD or reset.
- Counters saturate at 2^CNT_W−1; they do not wrap.
- DONE: all outputs hold; `Ack`=1 until `Start`=1 is seen.

## Timing
- All outputs are registered and change only at posedge `Clk`.
- `Start` 1→0 at edge k: `Run`=1 and `ProgCtr`=entry address from edge k onward; first instruction executes in cycle k.
- `Halt` sampled at edge k: `Ack`=1 and `Run`=0 from edge k; counters include the halt cycle.
- `Start` sampled in DONE at edge k: `Ack`=0 from edge k (state LOAD).
- Branch and next-PC decisions take effect at the same edge (zero-bubble, single-cycle core).
- No combinational path from any input to any output.

## Test plan
- Reset and load: `Reset_n`=0 for 2 cycles → all outputs 0, state IDLE. Then `ProgBase` = {300,200,100,0}, `ProgSel`=2, `Start` pulsed for 1 cycle → `ProgCtr`=200 and `Run`=1 on the following cycle.
- Sequential run and halt: from entry 0, 5 plain instructions then `Halt` → `Ack`=1, `ProgCtr`=5, `CycleCt`=6, `InstrCt`=6; all outputs hold for 10 idle cycles.
- Branches:
  - At PC=20, `Offset`=−4, `Flag`=1 → PC=16.
  - `Flag`=0 → PC=21.
  - `BranchAbs` with `Target`=700 while `BranchRelEn`=1 → PC=700.
- Stall priority: `Stall`=1 with `Halt`=1 and `BranchAbs`=1 for 3 cycles → PC holds, `CycleCt`+3, `InstrCt`+0, `Ack`=0. Releasing `Stall` with `Halt`=1 → DONE.
- Wrap and saturation:
  - PC=1023, plain step → PC=0, `Wrapped`=1.
  - PC=2, `Offset`=−3 → PC=1023, `Wrapped`=1.
  - With `CNT_W`=4, run 20 instructions → `CycleCt`=15.
- Restart and mid-run reset:
  - `Start`=1 mid-RUN → LOAD, counters 0, `Wrapped`=0.
  - `Reset_n`=0 during RUN → next edge all outputs 0.
  - Restart from DONE → `Ack` drops on the edge that samples `Start`.
